// File: rtl/picomips_core.sv
// rtl/picomips_core.sv - parametrised picoMIPS core with RUN/WAIT/HALT control
// Optional: define PICOMIPS_SYNC_EN to pass sw_hold through a 2-flop synchroniser.
module picomips_core #(
  parameter int DW    = 8,
  parameter int RBITS = 2,
  parameter int PSIZE = 5,
  parameter int ISIZE = 3 + 2 * RBITS + DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ISIZE-1:0] instr,
  input  logic [DW-1:0]    sw_data,
  input  logic             sw_hold,
  output logic [PSIZE-1:0] pc_out,
  output logic [DW-1:0]    led,
  output logic             out_valid,
  output logic             waiting,
  output logic             halted
);

  localparam int NREG = 2 ** RBITS;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_MULI = 3'b011;
  localparam logic [2:0] OP_IN   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;
  localparam logic [2:0] OP_OUT  = 3'b111;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]    regs [NREG];
  logic [2:0]       opcode;
  logic [RBITS-1:0] rd, rs;
  logic [DW-1:0]    imm;
  logic [DW-1:0]    rd_val, rs_val;
  logic [PSIZE-1:0] pc_inc, pc_n;
  logic             hs;
  logic             we;
  logic [DW-1:0]    wdata;
  logic             led_we;
  logic signed [2*DW-1:0] prod;
  logic             unused_prod_bits;

  assign opcode = instr[ISIZE-1 -: 3];
  assign rd     = instr[ISIZE-4 -: RBITS];
  assign rs     = instr[ISIZE-4-RBITS -: RBITS];
  assign imm    = instr[DW-1:0];
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];
  assign pc_inc = pc_out + PSIZE'(1);

  // Q1.(DW-1) fractional product: drop the duplicated sign bit and the low fraction bits
  assign prod = $signed(rs_val) * $signed(imm);
  assign unused_prod_bits = ^{prod[2*DW-1], prod[DW-2:0]};

  assign waiting = (state == S_WAIT);
  assign halted  = (state == S_HALT);

`ifdef PICOMIPS_SYNC_EN
  logic hold_meta, hold_sync;

  // two-stage synchroniser for the asynchronous switch handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_meta <= 1'b0;
      hold_sync <= 1'b0;
    end else begin
      hold_meta <= sw_hold;
      hold_sync <= hold_meta;
    end
  end

  assign hs = hold_sync;
`else
  assign hs = sw_hold;
`endif

  // control state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_RUN;
    else        state <= state_n;
  end

  // instruction decode: next state, next PC, register and output-port writes
  always_comb begin
    state_n = state;
    pc_n    = pc_out;
    we      = 1'b0;
    wdata   = '0;
    led_we  = 1'b0;
    case (state)
      S_RUN: begin
        pc_n = pc_inc;
        case (opcode)
          OP_HALT: begin
            pc_n    = pc_out;
            state_n = S_HALT;
          end
          OP_ADD: begin
            we    = 1'b1;
            wdata = rd_val + rs_val;
          end
          OP_ADDI: begin
            we    = 1'b1;
            wdata = rs_val + imm;
          end
          OP_MULI: begin
            we    = 1'b1;
            wdata = prod[2*DW-2:DW-1];
          end
          OP_IN: begin
            if (hs == imm[0]) begin
              we    = 1'b1;
              wdata = sw_data;
            end else begin
              pc_n    = pc_out;
              state_n = S_WAIT;
            end
          end
          OP_BEQ: begin
            if (rd_val == rs_val) pc_n = imm[PSIZE-1:0];
          end
          OP_J: begin
            pc_n = imm[PSIZE-1:0];
          end
          OP_OUT: begin
            led_we = 1'b1;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        // the PC is frozen, so instr still holds the pending IN
        if (hs == imm[0]) begin
          we      = 1'b1;
          wdata   = sw_data;
          pc_n    = pc_inc;
          state_n = S_RUN;
        end
      end
      default: ;
    endcase
  end

  // datapath registers: PC, register file and the output port
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out    <= '0;
      led       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      pc_out    <= pc_n;
      out_valid <= led_we;
      if (led_we) led <= rs_val;
      if (we) regs[rd] <= wdata;
    end
  end

endmodule

// File: doc/picomips_core.md
Name: picomips_core

Overview:
- Parametrised successor to the 8-bit picoMIPS datapath: data width, register count and program size set by parameters.
- Adds a three-state control FSM (RUN/WAIT/HALT), a conditional branch, and a fractional signed multiply-immediate.
- Adds a switch-input handshake with stall, and a registered output port with a valid strobe.
- Program ROM stays outside the core: the core drives pc_out and receives the instruction combinationally in the same cycle.

Parameters:
- DW, 8, data/register width and immediate width.
- RBITS, 2, register-number field width; NREG = 2**RBITS registers.
- PSIZE, 5, program-counter width; 2**PSIZE instructions.
- ISIZE, 3+2*RBITS+DW, instruction width (derived, do not override).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- instr  input  ISIZE  instruction at pc_out. Fields: [ISIZE-1 -: 3] opcode, next RBITS Rd, next RBITS Rs, [DW-1:0] imm.
- sw_data  input  DW  switch data operand.
- sw_hold  input  1  switch handshake level.
- pc_out  output  PSIZE  program counter.
- led  output  DW  registered output value.
- out_valid  output  1  one-cycle pulse when led is updated.
- waiting  output  1  high while in WAIT.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (reset==0 at a clk edge): pc_out=0, all registers=0, led=0, out_valid=0, state=RUN, waiting=0, halted=0. Reset overrides everything, including mid-WAIT and HALT.
- RUN executes one instruction per cycle. Rd/Rs writes and PC update occur at the clock edge. Default next PC = pc_out+1, wrapping 2**PSIZE-1 -> 0.
- Opcodes:
  - 000 HALT: PC holds; state->HALT.
  - 001 ADD: Rd = Rd + Rs, mod 2**DW.
  - 010 ADDI: Rd = Rs + imm, mod 2**DW.
  - 011 MULI: Rd = bits [2DW-2:DW-1] of signed(Rs)*signed(imm), i.e. Q1.(DW-1) fractional multiply, truncated, no saturation. Exception: 0x80*0x80 yields 0x80.
  - 100 IN: hs = sampled sw_hold. If hs==imm[0], Rd = sw_data and PC+1. Otherwise no write, PC holds, state->WAIT.
  - 101 BEQ: if Rd==Rs, PC = imm[PSIZE-1:0], else PC+1.
  - 110 J: PC = imm[PSIZE-1:0].
  - 111 OUT: led = Rs, out_valid=1 for that following cycle only; no register write.
- WAIT: waiting=1, PC and registers frozen. Each cycle the held IN instruction is re-evaluated. On hs==imm[0]: Rd = sw_data (value present that cycle), PC+1, state->RUN.
- HALT: halted=1; nothing changes until reset.
- If Rd==Rs, the register read uses the pre-edge value (ADD Rx,Rx doubles).
- Unused register-number bits do not exist: NREG is exactly 2**RBITS.
- out_valid is 0 in every cycle not immediately following an OUT. Consecutive OUTs give consecutive pulses.

Optional Feature:
- PICOMIPS_SYNC_EN defined: sw_hold passes through a 2-flop synchroniser reset to 0; hs = second flop. An sw_hold change is visible 2 cycles later.
- Undefined: hs = sw_hold sampled directly in the current cycle.
- Test expectations below assume the macro is undefined. With it defined, add 2 cycles to every handshake latency.

Test Plan (DW=8, RBITS=2, PSIZE=5):
- Hold reset low 3 cycles, then run ADDI R1,R0,0x05; ADDI R2,R1,0x03; ADD R1,R2; OUT R1 -> R1=0x0D; led=0x0D with one-cycle out_valid at cycle 4; pc_out=4.
- MULI R1,R2,0x40 with R2=0x40 -> R1=0x20. MULI with R2=0xC0 (-0.5) -> R1=0xE0. 0x80*0x80 -> 0x80.
- IN R3 with imm[0]=1, sw_hold=0, sw_data=0xA5 -> waiting=1, pc frozen. Raise sw_hold -> R3=0xA5 the same cycle, PC+1, waiting=0.
- BEQ R1,R2,0x1F with R1==R2 -> pc_out=31, next instruction at 31 then wraps to 0. Same BEQ with R1!=R2 -> pc_out=prev+1.
- HALT at address 6 -> halted=1, pc_out stays 6 for 10 cycles, led unchanged. Reset low one cycle -> pc_out=0, halted=0, registers 0.
- Reset asserted while in WAIT -> next cycle waiting=0, pc_out=0, led=0, no register write from the pending IN.
